// File: rtl/matrix_loader.sv
// matrix_loader: packs a stream of ELEM_W-bit elements, row-major, into one
// DIM x DIM matrix word, presents it with m_valid and holds it until m_ack.
module matrix_loader #(
   parameter int ELEM_W = 16,
   parameter int DIM    = 4
) (
   input  logic                      clk,
   input  logic                      reset,     // asynchronous, active-low
   input  logic                      start,
   input  logic [ELEM_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [DIM*DIM*ELEM_W-1:0] m_out,
   output logic                      m_valid,
   input  logic                      m_ack,
   output logic [$clog2(DIM*DIM+1)-1:0] count,
   output logic                      busy
);

   localparam int N     = DIM * DIM;
   localparam int MAT_W = N * ELEM_W;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [MAT_W-1:0]   m_out_q, m_out_d;
   logic               in_ready_q, in_ready_d;
   logic               m_valid_q, m_valid_d;
   logic               busy_q, busy_d;

   // Next-state, element packing and the status flags decoded from the next state
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      m_out_d = m_out_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               count_d = '0;
               m_out_d = '0;
            end
         end
         FILL: begin
            // A restart beats a same-cycle transfer; that element is dropped.
            if (start) begin
               count_d = '0;
               m_out_d = '0;
            end else if (in_valid) begin
               m_out_d[count_q*ELEM_W +: ELEM_W] = in_data;
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(N - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // start alone must not overwrite a matrix nobody has taken yet.
            if (m_ack) begin
               if (start) begin
                  state_d = FILL;
                  count_d = '0;
                  m_out_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d = (state_d == FILL);
      m_valid_d  = (state_d == DONE);
      busy_d     = (state_d != IDLE);
   end

   // State, data and registered status flags; reset clears everything at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         m_out_q    <= '0;
         in_ready_q <= 1'b0;
         m_valid_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         m_out_q    <= m_out_d;
         in_ready_q <= in_ready_d;
         m_valid_q  <= m_valid_d;
         busy_q     <= busy_d;
      end
   end

   assign in_ready = in_ready_q;
   assign m_valid  = m_valid_q;
   assign busy     = busy_q;
   assign count    = count_q;
   assign m_out    = m_out_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: fill, stalled fill, DONE hold, restart,
// asynchronous reset mid-load and ack+start back-to-back.
module tb_matrix_loader;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [15:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] m_out;
   logic         m_valid;
   logic         m_ack;
   logic [4:0]   count;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0]  d1 [16] = '{16'd5, 16'd8, 16'd9, 16'd2, 16'd7, 16'd3, 16'd8, 16'd4,
                             16'd6, 16'd5, 16'd4, 16'd3, 16'd8, 16'd5, 16'd7, 16'd6};
   logic [255:0] exp1;
   logic [255:0] exp4;

   matrix_loader #(.ELEM_W(16), .DIM(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .m_out    (m_out),
      .m_valid  (m_valid),
      .m_ack    (m_ack),
      .count    (count),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // expected matrices: element k at bits k*16 +: 16
      exp1 = '0;
      exp4 = '0;
      for (int k = 0; k < 16; k++) begin
         exp1[k*16 +: 16] = d1[k];
         exp4[k*16 +: 16] = 16'(k + 1);
      end

      reset = 1'b0; start = 1'b0; in_data = '0; in_valid = 1'b0; m_ack = 1'b0;
      tick();
      chk("rst_count", count, 0);
      chk("rst_mout", m_out, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_inready", in_ready, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b1;
      tick();
      // in_valid ignored in IDLE
      in_valid = 1'b1; in_data = 16'h1234;
      tick();
      chk("idle_ignore_count", count, 0);
      chk("idle_ignore_ready", in_ready, 0);
      in_valid = 1'b0;

      // 1: back-to-back fill
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_ready", in_ready, 1);
      chk("t1_busy", busy, 1);
      chk("t1_count0", count, 0);
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_data = d1[k];
         tick();
         if (k == 14) begin
            chk("t1_mvalid_early", m_valid, 0);
            chk("t1_count15", count, 15);
         end
      end
      in_valid = 1'b0;
      chk("t1_mvalid", m_valid, 1);
      chk("t1_ready_done", in_ready, 0);
      chk("t1_count16", count, 16);
      chk("t1_e00", m_out[15:0], 5);
      chk("t1_e03", m_out[63:48], 2);
      chk("t1_e10", m_out[79:64], 7);
      chk("t1_e33", m_out[255:240], 6);
      chk("t1_matrix", m_out, exp1);
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      chk("t1_ack_mvalid", m_valid, 0);
      chk("t1_ack_busy", busy, 0);

      // 2: every other cycle idle on in_valid
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1; in_data = d1[k];
         tick();
         if (k == 3) chk("t2_count4", count, 4);
         if (k == 15) break;
         in_valid = 1'b0; in_data = 16'hDEAD;
         tick();
         if (k == 3) chk("t2_stall_count4", count, 4);
         if (k == 14) chk("t2_mvalid_early", m_valid, 0);
      end
      in_valid = 1'b0;
      chk("t2_mvalid", m_valid, 1);
      chk("t2_matrix", m_out, exp1);
      chk("t2_count16", count, 16);

      // 3: DONE held against data and start
      in_valid = 1'b1; in_data = 16'hFFFF;
      for (int c = 0; c < 5; c++) begin
         start = (c == 2);
         tick();
      end
      start = 1'b0;
      chk("t3_hold_matrix", m_out, exp1);
      chk("t3_hold_ready", in_ready, 0);
      chk("t3_hold_mvalid", m_valid, 1);
      chk("t3_hold_count", count, 16);
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      in_valid = 1'b0;
      chk("t3_ack_mvalid", m_valid, 0);
      chk("t3_ack_busy", busy, 0);
      chk("t3_ack_matrix", m_out, exp1);
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      chk("t3_idle_ack_busy", busy, 0);

      // 4: restart after 7 elements, start beats a same-cycle transfer
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in_data = 16'(16'h100 + k);
         tick();
      end
      chk("t4_count7", count, 7);
      start = 1'b1; in_data = 16'hABCD;
      tick();
      start = 1'b0;
      chk("t4_restart_count", count, 0);
      chk("t4_restart_mout", m_out, 0);
      chk("t4_restart_ready", in_ready, 1);
      for (int k = 0; k < 16; k++) begin
         in_data = 16'(k + 1);
         tick();
      end
      in_valid = 1'b0;
      chk("t4_e00", m_out[15:0], 1);
      chk("t4_e33", m_out[255:240], 16);
      chk("t4_matrix", m_out, exp4);
      chk("t4_mvalid", m_valid, 1);
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;

      // 5: asynchronous reset after 10 elements
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_data = 16'(16'h200 + k);
         tick();
      end
      chk("t5_count10", count, 10);
      #3 reset = 1'b0;
      #1;
      chk("t5_async_count", count, 0);
      chk("t5_async_mout", m_out, 0);
      chk("t5_async_ready", in_ready, 0);
      chk("t5_async_busy", busy, 0);
      chk("t5_async_mvalid", m_valid, 0);
      #1 reset = 1'b1;
      tick();
      tick();
      chk("t5_post_count", count, 0);
      chk("t5_post_ready", in_ready, 0);
      in_valid = 1'b0;

      // 6: ack and start on the same edge in DONE
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_data = d1[k];
         tick();
      end
      in_valid = 1'b0;
      chk("t6_done", m_valid, 1);
      m_ack = 1'b1; start = 1'b1;
      tick();
      m_ack = 1'b0; start = 1'b0;
      chk("t6_mvalid", m_valid, 0);
      chk("t6_ready", in_ready, 1);
      chk("t6_count", count, 0);
      chk("t6_mout", m_out, 0);
      chk("t6_busy", busy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
